mem_stage: RTL
==============

# mem_stage

Parametrised memory-access pipeline stage for the bexkat1 core, sitting between execute and writeback. It turns a decoded load/store request into a registered Wishbone-style bus cycle with big-endian byte-lane selection. Load data is lane-aligned and sign- or zero-extended. Misaligned accesses, bus errors and bus timeouts are reported as precise exceptions. Non-memory instructions pass through with one cycle of latency.

## Interface
- DW, 32, data bus width in bits; legal values are 32 and 64.
- AW, 32, address width in bits.
- TIMEOUT, 255, maximum cycles spent in ACCESS before the cycle is aborted; 0 disables the timeout.

- clk_i  in  1  clock; everything is synchronous to the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  an instruction is present on the inputs.
- mem_i  in  1  the instruction is a memory access.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- signed_i  in  1  sign-extend load data.
- adr_i  in  AW  byte address of the access.
- wdata_i  in  DW  store data, right-justified.
- result_i  in  DW  ALU result, passed through for non-memory instructions.
- reg_write_i  in  1  the instruction writes a register.
- reg_addr_i  in  4  destination register.
- stall_i  in  1  downstream stall.
- stall_o  out  1  upstream hold.
- valid_o, result_o [DW], reg_write_o, reg_addr_o [4]  out  registered writeback outputs.
- exc_o  out  1  exception flag.
- exc_cause_o  out  2  1 misaligned, 2 bus error, 3 timeout or illegal size.
- fault_adr_o  out  AW  address of the faulting access.
- bus_cyc, bus_stb, bus_we  out  1  bus control.
- bus_adr  out  AW  bus address; low log2(DW/8) bits forced to 0.
- bus_sel  out  DW/8  byte-lane selects.
- bus_out  out  DW  bus write data.
- bus_in  in  DW  bus read data.
- bus_ack, bus_err  in  1  bus termination.

## Operation
- FSM states: IDLE, ACCESS, HOLD.
- Request decode: start = valid_i & mem_i & !stall_i in IDLE.
- Misalignment check:
  - half with adr[0] set; word with adr[1:0] nonzero; dword with adr[2:0] nonzero.
  - size 3 with DW=32 is illegal and reports cause 3.
- Misaligned or illegal request: no bus cycle. The outputs load exc_o=1, the cause, fault_adr_o=adr_i, reg_write_o=0 and valid_o=1 at the next edge. State stays IDLE.
- Aligned start: latch the request and go to ACCESS. stall_o=1.
- ACCESS:
  - bus_cyc, bus_stb, bus_we, bus_adr, bus_sel and bus_out are driven from the latched request registers (registered outputs).
  - The cycle terminates on bus_ack, bus_err, or timeout.
- Termination with !stall_i: outputs load and the FSM returns to IDLE. stall_o=0 in that cycle.
- Termination with stall_i: the data is captured into the hold register and the FSM goes to HOLD.
- HOLD: bus_cyc=0. When stall_i falls, outputs load from the hold register and the FSM goes to IDLE.
- Byte lanes are big-endian. Lane 0 is the MSB byte.
  - DW=32 byte: sel = 1000 >> adr[1:0].
  - DW=32 half: sel = 1100 when adr[1]=0, 0011 when adr[1]=1.
  - DW=32 word: sel = 1111.
  - DW=64 extends the same scheme over 8 lanes.
- Store data: low bytes of wdata_i replicated across every lane of the access size.
- Load data: the selected lanes are shifted to the LSBs, then sign-extended when signed_i=1, otherwise zero-extended.
- Load completion: result_o = extended data, reg_write_o = latched reg_write.
- Store completion: result_o = latched result, reg_write_o = 0.
- Error or timeout: exc_o=1, the cause, fault_adr_o = latched address, reg_write_o=0.
- Non-memory instruction in IDLE with !stall_i: passes through in one cycle. exc_o=0.
- Any stall_i with no completion: every output holds.

## Timing
- Reset: state=IDLE; bus_cyc, bus_stb and bus_we are 0. Every other output, including bus_adr, bus_sel and bus_out, is 0.
- Reset mid-ACCESS: bus_cyc=0 from the next cycle. No completion is reported.
- stall_o = stall_i | start | (ACCESS & !term) | (HOLD & stall_i).
  - It is combinational from bus_ack/bus_err.
  - Misaligned or illegal starts do not assert stall_o.
- Zero-wait slave (ack in the first ACCESS cycle): the memory op occupies 2 cycles and its result is visible 2 edges after start.
- Each wait state adds 1 cycle.
- Timeout: the counter clears on entering ACCESS and increments each ACCESS cycle. Term fires in the cycle the count equals TIMEOUT-1.
- Simultaneous events:
  - bus_err and bus_ack together: error wins.
  - bus_ack in the timeout cycle: ack wins.
- bus_cyc is never asserted in IDLE or HOLD. Back-to-back accesses therefore have at least 1 idle bus cycle between them.

## Test plan
- Signed byte load at adr 0x101, DW=32, bus_in 0x00_80_00_00, ack in the first ACCESS cycle -> bus_sel 0100; result_o 0xFFFFFF80 after 2 cycles; reg_write_o=1.
- Half store of wdata 0x1234 at adr 0x202 -> bus_sel 0011, bus_out 0x12341234, bus_we=1; reg_write_o=0.
- Word load at adr 0x3 -> no bus_cyc; next cycle exc_o=1, cause 1, fault_adr_o 0x3.
- TIMEOUT=4 and a slave that never acks -> bus_cyc high for exactly 4 cycles, then exc_o=1, cause 3, stall_o released.
- bus_err with bus_ack in the same cycle -> cause 2, no register write. stall_i held 3 cycles at completion -> outputs stay unchanged until release; FSM passes through HOLD.
- DW=64 dword load at adr 0x8, bus_in 0x0123456789ABCDEF -> sel 0xFF, result_o equals bus_in. rst_i asserted mid-ACCESS -> bus_cyc=0 next cycle and all outputs 0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage (execute -> writeback) for bexkat1.
//
// A decoded load/store becomes one registered Wishbone-style bus cycle with
// big-endian byte lanes (lane 0 = MSB byte). Load data is lane-aligned and
// sign/zero-extended. Misaligned or illegal-size requests, bus errors and bus
// timeouts are reported as precise exceptions. Non-memory instructions pass
// through with one cycle of latency.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i .. reg_addr_i   decoded instruction from execute
//   stall_i / stall_o       downstream stall in / upstream hold out
//   valid_o .. reg_addr_o   registered writeback outputs
//   exc_o, exc_cause_o      exception flag, cause (1 misaligned, 2 bus error,
//                           3 timeout or illegal size)
//   fault_adr_o             address of the faulting access
//   bus_*                   bus master interface (registered controls)
//   dbg_state               current FSM state (IDLE=0, ACCESS=1, HOLD=2)
//
// Handshake: an instruction is accepted from execute in a cycle where
// valid_i=1 and stall_o=0; writeback consumes valid_o in a cycle where
// stall_i=0, and while stall_i=1 every writeback output holds its value.
module mem_stage #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            mem_i,
  input  logic            we_i,
  input  logic [1:0]      size_i,
  input  logic            signed_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW-1:0]   result_i,
  input  logic            reg_write_i,
  input  logic [3:0]      reg_addr_i,
  input  logic            stall_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [DW-1:0]   result_o,
  output logic            reg_write_o,
  output logic [3:0]      reg_addr_o,
  output logic            exc_o,
  output logic [1:0]      exc_cause_o,
  output logic [AW-1:0]   fault_adr_o,
  output logic            bus_cyc,
  output logic            bus_stb,
  output logic            bus_we,
  output logic [AW-1:0]   bus_adr,
  output logic [DW/8-1:0] bus_sel,
  output logic [DW-1:0]   bus_out,
  input  logic [DW-1:0]   bus_in,
  input  logic            bus_ack,
  input  logic            bus_err,
  output logic [1:0]      dbg_state
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] MAX_SIZE = (DW == 64) ? 2'd3 : 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Bytes moved by an access; clamped so an illegal dword on a 32-bit bus
  // never produces out-of-range lane math.
  function automatic int size_bytes(input logic [1:0] size);
    int b;
    b = 1 << size;
    if (b > NB) b = NB;
    return b;
  endfunction

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic misaligned, illegal, req, go, bad;

  always_comb begin
    misaligned = 1'b0;
    case (size_i)
      2'd1:    misaligned = adr_i[0];
      2'd2:    misaligned = |adr_i[1:0];
      2'd3:    misaligned = |adr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign illegal = (size_i > MAX_SIZE);
  assign req     = (state_q == IDLE) & valid_i & mem_i & ~stall_i;
  assign go      = req & ~illegal & ~misaligned;
  assign bad     = req & (illegal | misaligned);

  // Lane selects and replicated store data for the incoming request.
  logic [NB-1:0] sel_c;
  logic [DW-1:0] wdata_rep;
  int            nb_in, off_in;

  always_comb begin
    sel_c  = '0;
    nb_in  = size_bytes(size_i);
    off_in = int'(adr_i[LB-1:0]);
    // Lane k maps to bit NB-1-k: lane 0 is the most significant byte.
    for (int k = 0; k < NB; k++) begin
      if (k >= off_in && k < off_in + nb_in) sel_c[NB-1-k] = 1'b1;
    end
  end

  always_comb begin
    wdata_rep = '0;
    case (size_i)
      2'd0:    wdata_rep = {NB{wdata_i[7:0]}};
      2'd1:    wdata_rep = {(NB/2){wdata_i[15:0]}};
      2'd2:    wdata_rep = {(NB/4){wdata_i[31:0]}};
      default: wdata_rep = wdata_i;
    endcase
  end

  // ---------------------------------------------------------------------
  // Latched request
  // ---------------------------------------------------------------------
  logic          req_we, req_signed, req_reg_write;
  logic [1:0]    req_size;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_result;
  logic [3:0]    req_reg_addr;

  // Load alignment: shift the selected lanes down to the LSBs, then extend.
  logic [DW-1:0] shifted, keep, load_ext;
  logic          sbit;
  int            nb_q, bits_q, sh_q;

  always_comb begin
    nb_q     = size_bytes(req_size);
    bits_q   = 8 * nb_q;
    sh_q     = 8 * (NB - int'(req_adr[LB-1:0]) - nb_q);
    shifted  = bus_in >> sh_q;
    keep     = (bits_q >= DW) ? {DW{1'b1}} : ((DW'(1) << bits_q) - DW'(1));
    sbit     = req_signed & (|(shifted & (DW'(1) << (bits_q - 1))));
    load_ext = (shifted & keep) | (sbit ? ~keep : '0);
  end

  // ---------------------------------------------------------------------
  // Termination
  // ---------------------------------------------------------------------
  logic [CW-1:0] tmo_cnt;
  logic          in_access, tmo_hit, t_ack, t_err, t_tmo, term;

  assign in_access = (state_q == ACCESS);
  assign tmo_hit   = (TIMEOUT != 0) && (int'(tmo_cnt) == TIMEOUT - 1);
  // Error beats ack; ack beats a timeout landing in the same cycle.
  assign t_err     = in_access & bus_err;
  assign t_ack     = in_access & bus_ack & ~bus_err;
  assign t_tmo     = in_access & tmo_hit & ~bus_ack & ~bus_err;
  assign term      = t_err | t_ack | t_tmo;

  // Completion payload, used both for direct load and for the hold register.
  logic [DW-1:0] cmp_result;
  logic          cmp_reg_write, cmp_exc;
  logic [1:0]    cmp_cause;
  logic [AW-1:0] cmp_fault;

  always_comb begin
    cmp_result    = '0;
    cmp_reg_write = 1'b0;
    cmp_exc       = 1'b0;
    cmp_cause     = 2'd0;
    cmp_fault     = '0;
    if (t_ack) begin
      if (req_we) begin
        cmp_result = req_result;
      end else begin
        cmp_result    = load_ext;
        cmp_reg_write = req_reg_write;
      end
    end else begin
      cmp_exc   = 1'b1;
      cmp_cause = t_err ? 2'd2 : 2'd3;
      cmp_fault = req_adr;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = ACCESS;
      ACCESS:  if (term) state_d = stall_i ? HOLD : IDLE;
      HOLD:    if (!stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall_o   = stall_i | go | (in_access & ~term) | ((state_q == HOLD) & stall_i);
  assign dbg_state = state_q;

  logic [DW-1:0] hold_result;
  logic          hold_reg_write, hold_exc;
  logic [1:0]    hold_cause;
  logic [AW-1:0] hold_fault;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      req_we         <= 1'b0;
      req_signed     <= 1'b0;
      req_reg_write  <= 1'b0;
      req_size       <= 2'd0;
      req_adr        <= '0;
      req_result     <= '0;
      req_reg_addr   <= 4'd0;
      tmo_cnt        <= '0;
      hold_result    <= '0;
      hold_reg_write <= 1'b0;
      hold_exc       <= 1'b0;
      hold_cause     <= 2'd0;
      hold_fault     <= '0;
      bus_cyc        <= 1'b0;
      bus_stb        <= 1'b0;
      bus_we         <= 1'b0;
      bus_adr        <= '0;
      bus_sel        <= '0;
      bus_out        <= '0;
      valid_o        <= 1'b0;
      result_o       <= '0;
      reg_write_o    <= 1'b0;
      reg_addr_o     <= 4'd0;
      exc_o          <= 1'b0;
      exc_cause_o    <= 2'd0;
      fault_adr_o    <= '0;
    end else begin
      state_q <= state_d;

      if (go) begin
        req_we        <= we_i;
        req_signed    <= signed_i;
        req_reg_write <= reg_write_i;
        req_size      <= size_i;
        req_adr       <= adr_i;
        req_result    <= result_i;
        req_reg_addr  <= reg_addr_i;
        bus_adr       <= {adr_i[AW-1:LB], {LB{1'b0}}};
        bus_sel       <= sel_c;
        bus_out       <= wdata_rep;
      end

      // Bus controls are high exactly while the FSM sits in ACCESS.
      bus_cyc <= (state_d == ACCESS);
      bus_stb <= (state_d == ACCESS);
      bus_we  <= (state_d == ACCESS) & (go ? we_i : req_we);

      if (go)             tmo_cnt <= '0;
      else if (in_access) tmo_cnt <= tmo_cnt + CW'(1);

      if (term & stall_i) begin
        hold_result    <= cmp_result;
        hold_reg_write <= cmp_reg_write;
        hold_exc       <= cmp_exc;
        hold_cause     <= cmp_cause;
        hold_fault     <= cmp_fault;
      end

      // Writeback outputs; any path not listed (stall_i high) holds them.
      if (bad) begin
        valid_o     <= 1'b1;
        result_o    <= '0;
        reg_write_o <= 1'b0;
        reg_addr_o  <= reg_addr_i;
        exc_o       <= 1'b1;
        exc_cause_o <= illegal ? 2'd3 : 2'd1;
        fault_adr_o <= adr_i;
      end else if (state_q == IDLE && !stall_i) begin
        if (valid_i && !mem_i) begin
          valid_o     <= 1'b1;
          result_o    <= result_i;
          reg_write_o <= reg_write_i;
          reg_addr_o  <= reg_addr_i;
          exc_o       <= 1'b0;
          exc_cause_o <= 2'd0;
          fault_adr_o <= '0;
        end else begin
          valid_o     <= 1'b0;
          reg_write_o <= 1'b0;
          exc_o       <= 1'b0;
        end
      end else if (in_access && !stall_i) begin
        if (term) begin
          valid_o     <= 1'b1;
          result_o    <= cmp_result;
          reg_write_o <= cmp_reg_write;
          reg_addr_o  <= req_reg_addr;
          exc_o       <= cmp_exc;
          exc_cause_o <= cmp_cause;
          fault_adr_o <= cmp_fault;
        end else begin
          valid_o     <= 1'b0;
          reg_write_o <= 1'b0;
          exc_o       <= 1'b0;
        end
      end else if (state_q == HOLD && !stall_i) begin
        valid_o     <= 1'b1;
        result_o    <= hold_result;
        reg_write_o <= hold_reg_write;
        reg_addr_o  <= req_reg_addr;
        exc_o       <= hold_exc;
        exc_cause_o <= hold_cause;
        fault_adr_o <= hold_fault;
      end
    end
  end

endmodule
